parking_count_sched: RTL and testbench
======================================

Name: parking_count_sched

Overview:
- Scheduler between N parking-lane FSMs and the single shared BCD up/down display counter.
- Each lane FSM emits one-cycle incr/decr pulses (car in / car out).
- This block queues the pulses per lane and arbitrates them round-robin onto the counter's single tick/sign interface, one event per slot.
- Keeps a binary occupancy mirror with capacity/empty guards and sticky error flags.

Parameters:
- NUM_LANES, 2, number of lane FSMs feeding events
- CAPACITY, 99, maximum occupancy (fits a 2-digit BCD display)
- PEND_W, 3, width of each per-lane pending-event counter (saturates at 2^PEND_W-1)
- GAP, 1, idle cycles forced after each issued tick (0 allowed)
- OCC_W, 7, occupancy width; must satisfy 2^OCC_W > CAPACITY

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- incr  in  NUM_LANES  per-lane one-cycle "car entered" pulse
- decr  in  NUM_LANES  per-lane one-cycle "car left" pulse
- cnt_ready  in  1  BCD counter accepts a tick this cycle
- err_clr  in  1  clears all sticky error flags
- tick  out  1  one-cycle count strobe to BCD counter
- sign  out  1  1 = count up, 0 = count down; valid when tick=1
- occupancy  out  OCC_W  current occupancy mirror
- full  out  1  occupancy == CAPACITY
- empty  out  1  occupancy == 0
- err_overflow  out  1  sticky: incr dropped because full
- err_underflow  out  1  sticky: decr dropped because empty
- err_lost  out  1  sticky: pulse lost to a saturated pending counter

Behaviour:
- Reset (async, reset_n=0): tick=0, sign=0, occupancy=0, full=0, empty=1, all err_*=0, all pending=0, rr pointer=lane 0, FSM=IDLE.
- Clocking: all outputs are registered; full/empty are decoded from the occupancy register.
- Per lane up_pend/dn_pend registers: +1 on incr/decr pulse, -1 when the lane is served for that direction.
- Arrival and service in the same cycle leave the count unchanged.
- incr and decr on the same lane in the same cycle are both queued; neither has priority.
- Arrival at saturation: the pulse is discarded and err_lost is set.
- Lane "requesting" = up_pend != 0 or dn_pend != 0.
- Round-robin: grant the first requesting lane at or after rr; after service, rr = granted+1 mod NUM_LANES.
- Within a granted lane, up is served if up_pend != 0, else down.
- FSM:
  - IDLE: if any lane requests and cnt_ready=1 -> ISSUE, latching the granted lane and direction.
  - ISSUE (one cycle): consume one pending event of the latched lane/direction.
    - Up while full: no tick, set err_overflow.
    - Down while empty: no tick, set err_underflow.
    - Otherwise: tick=1, sign=direction, occupancy +/-1 on the same edge.
    - Next state: GAP if GAP>0, else IDLE.
  - GAP: count GAP cycles with tick=0, then -> IDLE.
- Latency: a pulse sampled at edge k (empty queues, IDLE, cnt_ready=1) gives tick high from edge k+2 for exactly one cycle.
- Throughput: at most one tick per GAP+2 cycles.
- tick is never high for two consecutive cycles.
- cnt_ready=0 holds the FSM in IDLE; pending events are kept, not dropped.
- err_clr clears the flags. If err_clr and a new error event coincide, the set wins.
- occupancy never exceeds CAPACITY and never wraps below 0.

Decomposition:
- Shared package (the parking package): sched_state_t enum {IDLE, ISSUE, GAP}, direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0, default CAPACITY.
- One natural sub-module: rr_arbiter (NUM_LANES request vector + pointer -> one-hot grant plus index).
- Pending counters are instantiated in a generate loop inside the top module.

Test Plan:
- Reset then a single incr[0] pulse -> tick=1 with sign=1 exactly 2 edges later, occupancy=1, empty=0.
- incr[0] and incr[1] pulses in the same cycle (GAP=1) -> two ticks with sign=1, 3 cycles apart, lane 0 first; occupancy=2.
- incr[1] and decr[1] in the same cycle from occupancy=5 -> one up tick then one down tick; occupancy returns to 5; no errors.
- Preload occupancy=99 (CAPACITY), then incr[0] -> no tick, err_overflow=1, occupancy stays 99; err_clr -> err_overflow=0.
- Hold cnt_ready=0 while pulsing incr[0] 8 times (PEND_W=3) -> err_lost=1; release cnt_ready -> exactly 7 up ticks, occupancy=7.
- At empty, pulse decr[0] -> no tick, err_underflow=1. Then assert reset_n=0 mid-GAP -> all outputs at reset values immediately, with no clock edge.

Source files
------------

// File: rtl/parking_count_sched_pkg.sv
// Shared types and constants for the parking-lane event scheduler.
package parking_count_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGap
  } sched_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned DEFAULT_CAPACITY = 99;

endpackage

// File: rtl/parking_count_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting lane at or after ptr.
module parking_count_sched_rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    int unsigned j;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int unsigned off = 0; off < N; off++) begin
      j = (32'(ptr) + off) % N;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/parking_count_sched.sv
// Queues per-lane car in/out pulses and issues them one at a time to the
// shared BCD counter, keeping a guarded binary occupancy mirror.
module parking_count_sched
  import parking_count_sched_pkg::*;
#(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned CAPACITY  = DEFAULT_CAPACITY,
  parameter int unsigned PEND_W    = 3,
  parameter int unsigned GAP       = 1,
  parameter int unsigned OCC_W     = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_LANES-1:0] incr,
  input  logic [NUM_LANES-1:0] decr,
  input  logic                 cnt_ready,
  input  logic                 err_clr,
  output logic                 tick,
  output logic                 sign,
  output logic [OCC_W-1:0]     occupancy,
  output logic                 full,
  output logic                 empty,
  output logic                 err_overflow,
  output logic                 err_underflow,
  output logic                 err_lost
);

  localparam int unsigned   IW      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned   GW      = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GapLast = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [OCC_W-1:0] Cap  = OCC_W'(CAPACITY);

  sched_state_t         state_q, state_d;
  logic [IW-1:0]        lane_q, lane_d, rr_q, rr_d;
  logic                 dir_q, dir_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 tick_q, tick_d, sign_q, sign_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic                 ovf_q, unf_q, lost_q;
  logic                 ovf_set, unf_set;

  logic [NUM_LANES-1:0] up_req, dn_req, up_srv, dn_srv, lost;
  logic [NUM_LANES-1:0] gnt;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_valid;
  logic                 issue;

  assign issue = (state_q == StIssue);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [PEND_W-1:0] up_q, dn_q;

    assign up_srv[i] = issue && (lane_q == IW'(i)) && (dir_q == DIR_UP);
    assign dn_srv[i] = issue && (lane_q == IW'(i)) && (dir_q == DIR_DOWN);
    assign up_req[i] = |up_q;
    assign dn_req[i] = |dn_q;
    // A pulse arriving while its counter is being served replaces the consumed slot.
    assign lost[i]   = (incr[i] && !up_srv[i] && (up_q == '1)) ||
                       (decr[i] && !dn_srv[i] && (dn_q == '1));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        up_q <= '0;
        dn_q <= '0;
      end else begin
        if (incr[i] && !up_srv[i]) begin
          if (up_q != '1) up_q <= up_q + 1'b1;
        end else if (!incr[i] && up_srv[i]) begin
          up_q <= up_q - 1'b1;
        end
        if (decr[i] && !dn_srv[i]) begin
          if (dn_q != '1) dn_q <= dn_q + 1'b1;
        end else if (!decr[i] && dn_srv[i]) begin
          dn_q <= dn_q - 1'b1;
        end
      end
    end
  end

  parking_count_sched_rr_arbiter #(
    .N  (NUM_LANES),
    .IW (IW)
  ) u_arb (
    .req   (up_req | dn_req),
    .ptr   (rr_q),
    .gnt   (gnt),
    .idx   (gnt_idx),
    .valid (gnt_valid)
  );

  assign full  = (occ_q == Cap);
  assign empty = (occ_q == '0);

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    dir_d   = dir_q;
    rr_d    = rr_q;
    gap_d   = gap_q;
    tick_d  = 1'b0;
    sign_d  = sign_q;
    occ_d   = occ_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid && cnt_ready) begin
          state_d = StIssue;
          lane_d  = gnt_idx;
          dir_d   = up_req[gnt_idx] ? DIR_UP : DIR_DOWN;
        end
      end
      StIssue: begin
        rr_d = (lane_q == IW'(NUM_LANES - 1)) ? '0 : lane_q + 1'b1;
        if (dir_q == DIR_UP && full) begin
          ovf_set = 1'b1;
        end else if (dir_q == DIR_DOWN && empty) begin
          unf_set = 1'b1;
        end else begin
          tick_d = 1'b1;
          sign_d = dir_q;
          occ_d  = (dir_q == DIR_UP) ? occ_q + 1'b1 : occ_q - 1'b1;
        end
        gap_d   = '0;
        state_d = (GAP > 0) ? StGap : StIdle;
      end
      StGap: begin
        if (gap_q == GapLast) state_d = StIdle;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      lane_q  <= '0;
      dir_q   <= DIR_DOWN;
      rr_q    <= '0;
      gap_q   <= '0;
      tick_q  <= 1'b0;
      sign_q  <= 1'b0;
      occ_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      dir_q   <= dir_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
      tick_q  <= tick_d;
      sign_q  <= sign_d;
      occ_q   <= occ_d;
      // Set has priority over a coincident clear.
      ovf_q   <= ovf_set | (ovf_q & ~err_clr);
      unf_q   <= unf_set | (unf_q & ~err_clr);
      lost_q  <= (|lost) | (lost_q & ~err_clr);
    end
  end

  assign tick          = tick_q;
  assign sign          = sign_q;
  assign occupancy     = occ_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
  assign err_lost      = lost_q;

endmodule

// File: tb/tb_parking_count_sched.sv
// Directed bench for parking_count_sched with hand-computed expectations.
module tb_parking_count_sched;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] incr = '0, decr = '0;
  logic       cnt_ready = 1'b1, err_clr = 1'b0;
  logic       tick, sign, full, empty, err_overflow, err_underflow, err_lost;
  logic [6:0] occupancy;

  int n_checks = 0;
  int n_pass = 0;

  parking_count_sched dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .incr          (incr),
    .decr          (decr),
    .cnt_ready     (cnt_ready),
    .err_clr       (err_clr),
    .tick          (tick),
    .sign          (sign),
    .occupancy     (occupancy),
    .full          (full),
    .empty         (empty),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_lost      (err_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    incr      = '0;
    decr      = '0;
    cnt_ready = 1'b1;
    err_clr   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Drive a one-cycle pulse starting at the current negedge.
  task automatic pulse(input logic [1:0] i_v, input logic [1:0] d_v);
    incr = i_v;
    decr = d_v;
    @(negedge clk);
    incr = '0;
    decr = '0;
  endtask

  task automatic preload(input int n);
    for (int k = 0; k < n; k++) begin
      pulse(2'b01, 2'b00);
      repeat (2) @(negedge clk);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic run(input int cycles, output int ups, output int dns,
                     output int first_sign, output int consec);
    logic prev;
    prev = 1'b0;
    ups = 0;
    dns = 0;
    first_sign = -1;
    consec = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tick) begin
        if (first_sign < 0) first_sign = int'(sign);
        if (sign) ups++;
        else dns++;
        if (prev) consec++;
      end
      prev = tick;
    end
  endtask

  int ups, dns, fs, cons;

  initial begin
    // Reset values
    do_reset();
    check("rst_tick", tick, 0);
    check("rst_occ", occupancy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_errs", {err_overflow, err_underflow, err_lost}, 0);

    // Single incr: tick exactly two edges after sampling
    pulse(2'b01, 2'b00);
    check("t1_tick_n1", tick, 0);
    @(negedge clk);
    check("t1_tick_n2", tick, 0);
    @(negedge clk);
    check("t1_tick_n3", tick, 1);
    check("t1_sign", sign, 1);
    check("t1_occ", occupancy, 1);
    check("t1_empty", empty, 0);
    @(negedge clk);
    check("t1_tick_n4", tick, 0);

    // Two lanes together: ticks three cycles apart
    do_reset();
    pulse(2'b11, 2'b00);
    @(negedge clk);
    check("t2_tick_n2", tick, 0);
    @(negedge clk);
    check("t2_tick_n3", tick, 1);
    check("t2_sign_a", sign, 1);
    @(negedge clk);
    check("t2_tick_n4", tick, 0);
    @(negedge clk);
    check("t2_tick_n5", tick, 0);
    @(negedge clk);
    check("t2_tick_n6", tick, 1);
    check("t2_sign_b", sign, 1);
    check("t2_occ", occupancy, 2);

    // incr and decr on one lane together from occupancy 5
    do_reset();
    preload(5);
    check("t3_pre_occ", occupancy, 5);
    pulse(2'b10, 2'b10);
    run(12, ups, dns, fs, cons);
    check("t3_ups", ups, 1);
    check("t3_dns", dns, 1);
    check("t3_first_up", fs, 1);
    check("t3_occ", occupancy, 5);
    check("t3_errs", {err_overflow, err_underflow, err_lost}, 0);

    // Overflow at capacity, then clear
    do_reset();
    preload(99);
    check("t4_occ99", occupancy, 99);
    check("t4_full", full, 1);
    pulse(2'b01, 2'b00);
    run(8, ups, dns, fs, cons);
    check("t4_noticks", ups + dns, 0);
    check("t4_ovf", err_overflow, 1);
    check("t4_occ_hold", occupancy, 99);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t4_ovf_clr", err_overflow, 0);

    // Saturated pending counter while the counter is not ready
    do_reset();
    cnt_ready = 1'b0;
    for (int k = 0; k < 8; k++) pulse(2'b01, 2'b00);
    repeat (3) @(negedge clk);
    check("t5_lost", err_lost, 1);
    check("t5_hold_occ", occupancy, 0);
    cnt_ready = 1'b1;
    run(35, ups, dns, fs, cons);
    check("t5_ups", ups, 7);
    check("t5_dns", dns, 0);
    check("t5_no_b2b", cons, 0);
    check("t5_occ", occupancy, 7);

    // Underflow at empty, then async reset mid-gap
    do_reset();
    pulse(2'b00, 2'b01);
    run(6, ups, dns, fs, cons);
    check("t6_noticks", ups + dns, 0);
    check("t6_unf", err_underflow, 1);
    check("t6_occ", occupancy, 0);
    pulse(2'b01, 2'b00);
    repeat (2) @(negedge clk);
    check("t6_pre_tick", tick, 1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_tick", tick, 0);
    check("t6_rst_occ", occupancy, 0);
    check("t6_rst_empty", empty, 1);
    check("t6_rst_unf", err_underflow, 0);
    check("t6_rst_sign", sign, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
